dbi_tx_stage: RTL and testbench

DBI_TX_STAGE -- requirements
Module: dbi_tx_stage

---
 rtl/dbi_pkg.sv | 17 +
 rtl/dbi_vote.sv | 21 ++
 rtl/dbi_tx_stage.sv | 95 +++++++++
 tb/tb_dbi_tx_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dbi_pkg.sv
// Shared DBI definitions for the transmit stage and the receive-side decoder.
// Holds the word/bus widths, the inversion threshold and the 9-wire bus word type.
package dbi_pkg;

    localparam int DBI_W      = 8;
    localparam int BUS_W      = DBI_W + 1;
    localparam int DBI_THRESH = 5;

    // One 9-wire bus state: the DBI line plus the (possibly inverted) data lanes.
    typedef struct packed {
        logic             dbi;
        logic [DBI_W-1:0] data;
    } dbi_bus_t;

    localparam dbi_bus_t BUS_IDLE = '{dbi: 1'b0, data: '0};

endpackage

// File: rtl/dbi_vote.sv
// DBI inversion vote: asserts o_inv when the transition vector has at least
// DBI_THRESH set bits, i.e. when inverting strictly reduces bus toggles.
module dbi_vote
    import dbi_pkg::*;
(
    input  logic [BUS_W-1:0] i_t,
    output logic             o_inv
);

    logic [3:0] w_cnt;

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < BUS_W; i++) begin
            w_cnt = w_cnt + 4'(i_t[i]);
        end
    end

    assign o_inv = (w_cnt >= 4'(DBI_THRESH));

endmodule

// File: rtl/dbi_tx_stage.sv
// DBI transmit stage: one-deep registered stage driving the 9-wire bus.
// Optional statistics counters are built when DBI_TX_STATS_EN is defined.
module dbi_tx_stage
    import dbi_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbi_en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DBI_W-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DBI_W-1:0]  m_data,
`ifdef DBI_TX_STATS_EN
    output logic              m_dbi,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] inv_count,
    output logic [STAT_W-1:0] xfer_count
`else
    output logic              m_dbi
`endif
);

    if (STAT_W < 1) begin : g_stat_w_chk
        $error("STAT_W must be at least 1");
    end

    logic             r_valid;
    dbi_bus_t         r_bus;
    logic [BUS_W-1:0] w_t;
    logic             w_vote;
    logic             w_inv;
    logic             w_load;

    assign s_ready = !r_valid || m_ready;
    assign w_load  = s_valid && s_ready;

    // The register always holds the last word on the wires, drained or not,
    // so it doubles as the previous bus state for the toggle comparison.
    assign w_t = {r_bus.dbi, s_data ^ r_bus.data};

    dbi_vote u_vote (
        .i_t   (w_t),
        .o_inv (w_vote)
    );

    assign w_inv = dbi_en && w_vote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_bus   <= BUS_IDLE;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_bus.dbi  <= w_inv;
            r_bus.data <= w_inv ? ~s_data : s_data;
        end else if (m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_bus.data;
    assign m_dbi   = r_bus.dbi;

`ifdef DBI_TX_STATS_EN
    logic [STAT_W-1:0] r_inv_cnt;
    logic [STAT_W-1:0] r_xfer_cnt;

    // Counters saturate at all-ones; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv_cnt  <= '0;
            r_xfer_cnt <= '0;
        end else if (clr_stats) begin
            r_inv_cnt  <= '0;
            r_xfer_cnt <= '0;
        end else if (w_load) begin
            if (!(&r_xfer_cnt)) begin
                r_xfer_cnt <= r_xfer_cnt + STAT_W'(1);
            end
            if (w_inv && !(&r_inv_cnt)) begin
                r_inv_cnt <= r_inv_cnt + STAT_W'(1);
            end
        end
    end

    assign inv_count  = r_inv_cnt;
    assign xfer_count = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_dbi_tx_stage.sv
// Scoreboard bench for dbi_tx_stage; define DBI_TX_STATS_EN to also cover
// the statistics counters (instantiated with STAT_W=4).
module tb_dbi_tx_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dbi_en = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_dbi;
`ifdef DBI_TX_STATS_EN
    logic       clr_stats = 1'b0;
    logic [3:0] inv_count;
    logic [3:0] xfer_count;
`endif

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef DBI_TX_STATS_EN
    dbi_tx_stage #(.STAT_W(4)) dut (
        .clk(clk), .rst(rst), .dbi_en(dbi_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dbi(m_dbi),
        .clr_stats(clr_stats), .inv_count(inv_count), .xfer_count(xfer_count)
    );
`else
    dbi_tx_stage dut (
        .clk(clk), .rst(rst), .dbi_en(dbi_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dbi(m_dbi)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every word presented while the sink is ready is scored.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready_eq", {31'd0, s_ready}, {31'd0, (!m_valid || m_ready)});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {23'd0, m_dbi, m_data}, 32'h1ff);
                end else begin
                    chk("bus_word", {23'd0, m_dbi, m_data}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [8:0] e);
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back(e);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_bus", {23'd0, m_dbi, m_data}, 32'h000);
        chk("rst_ready", {31'd0, s_ready}, 32'd1);

        // FF from idle inverts; 0F (t popcount 5) inverts; F7 (t popcount 4) does not
        dbi_en = 1'b1;
        send(8'hFF, 9'h100);
        send(8'h0F, 9'h1F0);
        send(8'hF7, 9'h0F7);
        idle(3);
        chk("drained_valid", {31'd0, m_valid}, 32'd0);
        chk("bus_retained", {23'd0, m_dbi, m_data}, 32'h0F7);

        // dbi_en=0 passes raw; change of dbi_en applies to the next word only
        do_reset();
        dbi_en = 1'b0;
        send(8'hFF, 9'h0FF);
        send(8'h00, 9'h000);
        dbi_en = 1'b1;
        send(8'hFF, 9'h100);
        idle(3);

        // Backpressure: hold for 4 cycles, then hand off with no bubble
        m_ready = 1'b0;
        send(8'hA5, 9'h15A);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        exp_q.push_back(9'h1C3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_ready", {31'd0, s_ready}, 32'd0);
            chk("stall_bus", {22'd0, m_valid, m_dbi, m_data}, 32'h35A);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("no_bubble", {22'd0, m_valid, m_dbi, m_data}, 32'h3C3);
        idle(3);

        // Asynchronous reset while a word is pending
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("pend_valid", {31'd0, m_valid}, 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst", {22'd0, m_valid, m_dbi, m_data}, 32'h000);
        idle(1);
        rst = 1'b0;
        m_ready = 1'b1;
        idle(1);
        send(8'hE0, 9'h0E0);
        send(8'h1F, 9'h1E0);
        idle(3);

`ifdef DBI_TX_STATS_EN
        do_reset();
        chk("stat_rst", {24'd0, inv_count, xfer_count}, 32'h00);
        for (int i = 0; i < 20; i++) send(8'hFF, 9'h100);
        idle(1);
        chk("stat_sat", {24'd0, inv_count, xfer_count}, 32'hFF);
        clr_stats = 1'b1;
        send(8'hFF, 9'h100);
        clr_stats = 1'b0;
        chk("stat_clr", {24'd0, inv_count, xfer_count}, 32'h00);
        send(8'hFF, 9'h100);
        send(8'h00, 9'h000);
        idle(1);
        chk("stat_count", {24'd0, inv_count, xfer_count}, 32'h12);
        idle(2);
`endif

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
